// File: rtl/exerion_hs_ram_arbiter_pkg.sv
// Shared types for the work-RAM arbiter between the Z80 bus and the
// hiscore engine: FSM state encoding, port owner and width defaults.
package exerion_hs_arb_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOLD_REQ = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_HS_OWN   = 3'd3,
        ST_RELEASE  = 3'd4
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_CPU  = 2'd0,
        OWN_NONE = 2'd1,
        OWN_HS   = 2'd2
    } owner_e;

    // Who drives the RAM port in a given arbiter state.
    function automatic owner_e owner_of(arb_state_e s);
        case (s)
            ST_IDLE, ST_HOLD_REQ: return OWN_CPU;
            ST_HS_OWN:            return OWN_HS;
            default:              return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/exerion_hs_ram_arbiter_if.sv
// Bus bundle around the arbiter: CPU side, hiscore side and RAM port.
// slave = arbiter view, master = the surrounding system (or bench).
interface exerion_hs_ram_arbiter_if #(
    parameter int AW = exerion_hs_arb_pkg::DEF_AW,
    parameter int DW = exerion_hs_arb_pkg::DEF_DW
);
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_wr;
    logic          cpu_halted;
    logic [AW-1:0] hs_address;
    logic [DW-1:0] hs_data_in;
    logic          hs_write;
    logic          hs_access_read;
    logic          hs_access_write;
    logic [DW-1:0] ram_dout;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_we;
    logic [DW-1:0] cpu_dout;
    logic [DW-1:0] hs_data_out;
    logic          cpu_hold;
    logic          hs_grant;
    logic          collision;
    logic          timeout_err;

    modport slave (
        input  cpu_addr, cpu_din, cpu_wr, cpu_halted,
        input  hs_address, hs_data_in, hs_write,
        input  hs_access_read, hs_access_write, ram_dout,
        output ram_addr, ram_din, ram_we, cpu_dout,
        output hs_data_out, cpu_hold, hs_grant,
        output collision, timeout_err
    );

    modport master (
        output cpu_addr, cpu_din, cpu_wr, cpu_halted,
        output hs_address, hs_data_in, hs_write,
        output hs_access_read, hs_access_write, ram_dout,
        input  ram_addr, ram_din, ram_we, cpu_dout,
        input  hs_data_out, cpu_hold, hs_grant,
        input  collision, timeout_err
    );

endinterface

// File: rtl/exerion_hs_ram_arbiter_port_mux.sv
// Combinational RAM port mux. The NONE owner parks the address on the
// hiscore side with writes disabled so the bus can settle safely.
module exerion_hs_port_mux
    import exerion_hs_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  owner_e        owner,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    input  logic          cpu_wr,
    input  logic [AW-1:0] hs_address,
    input  logic [DW-1:0] hs_data_in,
    input  logic          hs_write,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we
);

    // Select address, data and write enable by current owner.
    always_comb begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = cpu_wr;
        case (owner)
            OWN_CPU: begin
                ram_addr = cpu_addr;
                ram_din  = cpu_din;
                ram_we   = cpu_wr;
            end
            OWN_HS: begin
                ram_addr = hs_address;
                ram_din  = hs_data_in;
                ram_we   = hs_write;
            end
            default: begin
                ram_addr = hs_address;
                ram_din  = hs_data_in;
                ram_we   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/exerion_hs_ram_arbiter.sv
// Work-RAM arbiter: holds the CPU, settles, grants the port to hiscore.
// Optional HOLD_REQ watchdog: define EXERION_HS_ARB_TIMEOUT_EN.
module exerion_hs_ram_arbiter
    import exerion_hs_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 1024
) (
    input logic                   clk_sys,
    input logic                   reset,
    exerion_hs_ram_arbiter_if.slave bus
);

    if (SETTLE < 1 || SETTLE > 15 || TIMEOUT < 1) begin : g_bad_param
        $error("exerion_hs_ram_arbiter: SETTLE/TIMEOUT out of range");
    end

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    arb_state_e    state_q, state_d;
    logic [3:0]    set_cnt_q, set_cnt_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          hs_grant_q, hs_grant_d;
    logic [DW-1:0] hs_data_out_q, hs_data_out_d;
    logic          collision_q, collision_d;
    logic          hs_intent;
    owner_e        owner;

    assign hs_intent = bus.hs_access_read | bus.hs_access_write;
    assign owner     = owner_of(state_q);

`ifdef EXERION_HS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_err_q, timeout_err_d;
`endif

    // Next-state, counters, read-data capture and sticky flags.
    always_comb begin
        state_d       = state_q;
        set_cnt_d     = set_cnt_q;
        hs_data_out_d = hs_data_out_q;
        collision_d   = collision_q |
                        (bus.cpu_wr & (owner != OWN_CPU));
`ifdef EXERION_HS_ARB_TIMEOUT_EN
        tmo_cnt_d     = '0;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (hs_intent) state_d = ST_HOLD_REQ;
            end
            ST_HOLD_REQ: begin
                if (bus.cpu_halted) begin
                    state_d   = ST_SETTLE;
                    set_cnt_d = SETTLE_LD;
                end
`ifdef EXERION_HS_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end
            ST_SETTLE: begin
                if (set_cnt_q == 4'd0) state_d = ST_HS_OWN;
                else set_cnt_d = set_cnt_q - 4'd1;
            end
            ST_HS_OWN: begin
                hs_data_out_d = bus.ram_dout;
                if (!hs_intent) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        cpu_hold_d = (state_d != ST_IDLE);
        hs_grant_d = (state_d == ST_HS_OWN);
    end

    // State and registered outputs; reset hands the port back at once.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            set_cnt_q     <= 4'd0;
            cpu_hold_q    <= 1'b0;
            hs_grant_q    <= 1'b0;
            hs_data_out_q <= '0;
            collision_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            set_cnt_q     <= set_cnt_d;
            cpu_hold_q    <= cpu_hold_d;
            hs_grant_q    <= hs_grant_d;
            hs_data_out_q <= hs_data_out_d;
            collision_q   <= collision_d;
        end
    end

`ifdef EXERION_HS_ARB_TIMEOUT_EN
    // HOLD_REQ watchdog counter and its sticky error flag.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tmo_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    exerion_hs_port_mux #(
        .AW(AW),
        .DW(DW)
    ) u_port_mux (
        .owner      (owner),
        .cpu_addr   (bus.cpu_addr),
        .cpu_din    (bus.cpu_din),
        .cpu_wr     (bus.cpu_wr),
        .hs_address (bus.hs_address),
        .hs_data_in (bus.hs_data_in),
        .hs_write   (bus.hs_write),
        .ram_addr   (bus.ram_addr),
        .ram_din    (bus.ram_din),
        .ram_we     (bus.ram_we)
    );

    assign bus.cpu_dout    = bus.ram_dout;
    assign bus.hs_data_out = hs_data_out_q;
    assign bus.cpu_hold    = cpu_hold_q;
    assign bus.hs_grant    = hs_grant_q;
    assign bus.collision   = collision_q;

endmodule

// File: tb/tb_exerion_hs_ram_arbiter.sv
// Bench for exerion_hs_ram_arbiter: directed scenario plus random
// traffic checked every cycle against a behavioural arbiter model.
module tb_exerion_hs_ram_arbiter;

    localparam int SETTLE = 2;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic run_cmp = 1'b0;
    int   n_chk   = 0;
    int   n_fail  = 0;

    always #5 clk_sys = ~clk_sys;

    exerion_hs_ram_arbiter_if #(.AW(16), .DW(8)) bus ();

    exerion_hs_ram_arbiter #(
        .AW(16), .DW(8), .SETTLE(SETTLE), .TIMEOUT(16)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus)
    );

    // Synchronous RAM, 1-cycle read latency; unwritten cells hold a pattern.
    logic [7:0] mem  [0:65535];
    logic       seen [0:65535];

    function automatic logic [7:0] pat(input logic [15:0] a);
        if (a == 16'h6100) return 8'h3C;
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk_sys) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr]  <= bus.ram_din;
            seen[bus.ram_addr] <= 1'b1;
        end
        bus.ram_dout <= (seen[bus.ram_addr] === 1'b1) ?
                        mem[bus.ram_addr] : pat(bus.ram_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // Behavioural model. Phase: 0 free, 1 awaiting halt, 2 settling,
    // 3 hiscore owns the port, 4 handing back. m_left = settle cycles left.
    int         m_phase;
    int         m_left;
    logic       m_coll;
    logic [7:0] m_hsdo;

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            m_left  = 0;
            m_coll  = 1'b0;
            m_hsdo  = 8'h00;
        end else begin
            if (bus.cpu_wr && m_phase >= 2) m_coll = 1'b1;
            if (m_phase == 0) begin
                if (bus.hs_access_read || bus.hs_access_write) m_phase = 1;
            end else if (m_phase == 1) begin
                if (bus.cpu_halted) begin
                    m_phase = 2;
                    m_left  = SETTLE;
                end
            end else if (m_phase == 2) begin
                m_left = m_left - 1;
                if (m_left == 0) m_phase = 3;
            end else if (m_phase == 3) begin
                m_hsdo = bus.ram_dout;
                if (!bus.hs_access_read && !bus.hs_access_write) m_phase = 4;
            end else begin
                m_phase = 0;
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk_sys) begin
        if (run_cmp && !reset) begin
            if (m_phase <= 1) begin
                chk("ram_addr_cpu", bus.ram_addr, bus.cpu_addr);
                chk("ram_din_cpu", bus.ram_din, bus.cpu_din);
                chk("ram_we_cpu", bus.ram_we, bus.cpu_wr);
            end else begin
                chk("ram_addr_hs", bus.ram_addr, bus.hs_address);
                if (m_phase == 3) begin
                    chk("ram_din_hs", bus.ram_din, bus.hs_data_in);
                    chk("ram_we_hs", bus.ram_we, bus.hs_write);
                end else begin
                    chk("ram_we_off", bus.ram_we, 1'b0);
                end
            end
            chk("cpu_dout", bus.cpu_dout, bus.ram_dout);
            chk("cpu_hold", bus.cpu_hold, m_phase != 0);
            chk("hs_grant", bus.hs_grant, m_phase == 3);
            chk("hs_data_out", bus.hs_data_out, m_hsdo);
            chk("collision", bus.collision, m_coll);
            chk("timeout_err", bus.timeout_err, 1'b0);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #2;
    endtask

    logic intent_on;

    initial begin
        bus.cpu_addr        = 16'h0000;
        bus.cpu_din         = 8'h00;
        bus.cpu_wr          = 1'b0;
        bus.cpu_halted      = 1'b0;
        bus.hs_address      = 16'h0000;
        bus.hs_data_in      = 8'h00;
        bus.hs_write        = 1'b0;
        bus.hs_access_read  = 1'b0;
        bus.hs_access_write = 1'b0;
        intent_on           = 1'b0;
        tick(3);
        reset   = 1'b0;
        run_cmp = 1'b1;

        chk("rst_cpu_hold", bus.cpu_hold, 1'b0);
        chk("rst_hs_grant", bus.hs_grant, 1'b0);
        chk("rst_hs_data_out", bus.hs_data_out, 8'h00);
        chk("rst_collision", bus.collision, 1'b0);
        chk("rst_timeout_err", bus.timeout_err, 1'b0);

        bus.cpu_wr   = 1'b1;
        bus.cpu_addr = 16'h6000;
        bus.cpu_din  = 8'hA5;
        #1;
        chk("cpu_path_we", bus.ram_we, 1'b1);
        chk("cpu_path_addr", bus.ram_addr, 16'h6000);
        chk("cpu_path_din", bus.ram_din, 8'hA5);
        chk("cpu_path_hold", bus.cpu_hold, 1'b0);
        tick();
        bus.cpu_wr = 1'b0;

        // cycle 0: read intent
        bus.hs_access_read = 1'b1;
        bus.hs_address     = 16'h6100;
        tick();
        chk("c1_cpu_hold", bus.cpu_hold, 1'b1);
        tick(2);
        bus.cpu_halted = 1'b1;
        tick(2);
        chk("c5_no_grant", bus.hs_grant, 1'b0);
        tick();
        chk("c6_grant", bus.hs_grant, 1'b1);
        chk("c6_data_old", bus.hs_data_out, 8'h00);
        tick(2);
        chk("c8_read_data", bus.hs_data_out, 8'h3C);

        bus.hs_access_write = 1'b1;
        bus.hs_write        = 1'b1;
        bus.hs_data_in      = 8'h77;
        bus.hs_address      = 16'h6105;
        #1;
        chk("hs_wr_we", bus.ram_we, 1'b1);
        chk("hs_wr_addr", bus.ram_addr, 16'h6105);
        chk("hs_wr_din", bus.ram_din, 8'h77);
        tick();
        bus.hs_write = 1'b0;
        bus.cpu_wr   = 1'b1;
        bus.cpu_addr = 16'h6002;
        bus.cpu_din  = 8'hEE;
        #1;
        chk("coll_we_dropped", bus.ram_we, 1'b0);
        chk("hs_wr_mem", mem[16'h6105], 8'h77);
        tick();
        bus.cpu_wr = 1'b0;
        chk("coll_set", bus.collision, 1'b1);
        bus.hs_access_read  = 1'b0;
        bus.hs_access_write = 1'b0;
        tick();
        chk("rel_hold", bus.cpu_hold, 1'b1);
        chk("rel_grant", bus.hs_grant, 1'b0);
        tick();
        chk("idle_hold", bus.cpu_hold, 1'b0);
        chk("coll_sticky", bus.collision, 1'b1);

        bus.hs_access_read = 1'b1;
        tick(4);
        chk("regrant", bus.hs_grant, 1'b1);
        reset = 1'b1;
        #1;
        chk("arst_hold", bus.cpu_hold, 1'b0);
        chk("arst_grant", bus.hs_grant, 1'b0);
        chk("arst_coll", bus.collision, 1'b0);
        bus.hs_access_read = 1'b0;
        bus.cpu_halted     = 1'b0;
        #1;
        reset        = 1'b0;
        bus.cpu_wr   = 1'b1;
        bus.cpu_addr = 16'h6000;
        bus.cpu_din  = 8'h5A;
        #1;
        chk("post_rst_we", bus.ram_we, 1'b1);
        chk("post_rst_addr", bus.ram_addr, 16'h6000);
        tick();
        bus.cpu_wr = 1'b0;
        #1;
        chk("post_rst_mem", mem[16'h6000], 8'h5A);

        // Random traffic: bursty intents, flaky halt, stray CPU writes.
        for (int i = 0; i < 4000; i++) begin
            tick();
            if ($urandom_range(11) == 0) intent_on = ~intent_on;
            bus.hs_access_read  = intent_on & ($urandom_range(1) == 1);
            bus.hs_access_write = intent_on & ~bus.hs_access_read;
            bus.cpu_halted      = ($urandom_range(2) == 0);
            bus.cpu_wr          = ($urandom_range(3) == 0);
            bus.cpu_addr        = 16'h6000 | 16'($urandom_range(255));
            bus.cpu_din         = 8'($urandom);
            bus.hs_write        = ($urandom_range(1) == 1);
            bus.hs_address      = 16'h6000 | 16'($urandom_range(255));
            bus.hs_data_in      = 8'($urandom);
            if ($urandom_range(699) == 0) begin
                reset = 1'b1;
                #1;
                reset = 1'b0;
            end
        end

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
